usr_deser: RTL



---
 rtl/usr_deser.sv | 109 ++++++++++
 1 files changed

// File: rtl/usr_deser.sv
// Serial-to-parallel receiver for a universal shift register stream.
// Rebuilds LSB-first or MSB-first frames and offers each word on a one-deep valid/ready buffer.
module usr_deser #(
   parameter int WIDTH = 8
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic                           i_ser_in,
   input  logic                           i_ser_valid,
   input  logic                           i_dir,
   input  logic                           i_clr,
   output logic [WIDTH-1:0]               o_par_out,
   output logic                           o_out_valid,
   input  logic                           i_out_ready,
   output logic                           o_busy,
   output logic [$clog2(WIDTH+1)-1:0]     o_bit_cnt,
   output logic                           o_overrun
);

   localparam int CW = $clog2(WIDTH+1);

   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_ACTIVE = 1'b1;

   logic [0:0]       r_state;
   logic [WIDTH-1:0] r_sreg;
   logic [CW-1:0]    r_bit_cnt;
   logic             r_fdir;
   logic [WIDTH-1:0] r_par_out;
   logic             r_out_valid;
   logic             r_overrun;

   logic             w_fdir;
   logic [WIDTH-1:0] w_sreg_next;
   logic             w_last;
   logic             w_drain;
   logic             w_complete;
   logic             w_load;

   // Frame direction is taken from i_dir only on the first bit of a frame.
   always_comb begin
      w_fdir      = r_fdir;
      w_sreg_next = r_sreg;
      if (r_state == S_IDLE) begin
         w_fdir = i_dir;
      end else begin
         w_fdir = r_fdir;
      end
      if (w_fdir) begin
         w_sreg_next = {r_sreg[WIDTH-2:0], i_ser_in};
      end else begin
         w_sreg_next = {i_ser_in, r_sreg[WIDTH-1:1]};
      end
   end

   assign w_last     = (r_bit_cnt == CW'(WIDTH-1));
   assign w_drain    = r_out_valid && i_out_ready;
   assign w_complete = i_ser_valid && !i_clr && w_last;
   assign w_load     = w_complete && (!r_out_valid || w_drain);

   // Frame assembly, bit counting and the sticky overrun flag.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= S_IDLE;
         r_sreg    <= '0;
         r_bit_cnt <= '0;
         r_fdir    <= 1'b0;
         r_overrun <= 1'b0;
      end else if (i_clr) begin
         r_state   <= S_IDLE;
         r_sreg    <= '0;
         r_bit_cnt <= '0;
         r_overrun <= 1'b0;
      end else if (i_ser_valid) begin
         r_fdir <= w_fdir;
         r_sreg <= w_sreg_next;
         if (w_last) begin
            r_bit_cnt <= '0;
            r_state   <= S_IDLE;
            if (!w_load) begin
               r_overrun <= 1'b1;
            end
         end else begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
            r_state   <= S_ACTIVE;
         end
      end
   end

   // Output buffer: clr leaves it alone, a drain and a reload may share one edge.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_par_out   <= '0;
         r_out_valid <= 1'b0;
      end else if (w_load) begin
         r_par_out   <= w_sreg_next;
         r_out_valid <= 1'b1;
      end else if (w_drain) begin
         r_out_valid <= 1'b0;
      end
   end

   assign o_par_out   = r_par_out;
   assign o_out_valid = r_out_valid;
   assign o_busy      = (r_state == S_ACTIVE);
   assign o_bit_cnt   = r_bit_cnt;
   assign o_overrun   = r_overrun;

endmodule
